// File: rtl/vscpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vscpu_pkg
// Description : Shared definitions for the VerySimpleCPU memory side:
//               address/data widths, the responder FSM state type and the
//               4-bit {op,imm} instruction opcodes also used by the CPU core.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package vscpu_pkg;

  localparam int VSCPU_ADDR_W = 14;
  localparam int VSCPU_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } mem_state_t;

  // Opcode field is {op[2:0], imm}; the low bit selects the immediate form.
  localparam logic [3:0] OP_ADD      = 4'h0;
  localparam logic [3:0] OP_ADDI     = 4'h1;
  localparam logic [3:0] OP_NAND     = 4'h2;
  localparam logic [3:0] OP_NANDI    = 4'h3;
  localparam logic [3:0] OP_SRL      = 4'h4;
  localparam logic [3:0] OP_SRLI     = 4'h5;
  localparam logic [3:0] OP_LT       = 4'h6;
  localparam logic [3:0] OP_LTI      = 4'h7;
  localparam logic [3:0] OP_CP       = 4'h8;
  localparam logic [3:0] OP_CPI      = 4'h9;
  localparam logic [3:0] OP_CP_IND   = 4'hA;
  localparam logic [3:0] OP_CP_INDI  = 4'hB;
  localparam logic [3:0] OP_BZJ      = 4'hC;
  localparam logic [3:0] OP_BZJI     = 4'hD;

  function automatic logic op_is_imm(input logic [3:0] opc);
    return opc[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vscpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : vscpu_mem_responder_if
// Description : CPU RAM port plus program-loader word stream between the
//               CPU/loader side (master) and the memory responder (slave).
// Signals     : wrEn, addr_toRAM, data_toRAM   CPU request
//               data_fromRAM                    registered read data
//               ld_start, ld_valid, ld_data,
//               ld_last                         loader stream
//               ld_ready                        loader accept
// Revision    : 1.0  initial release
// ============================================================================
interface vscpu_mem_responder_if #(
  parameter int SIZE = vscpu_pkg::VSCPU_ADDR_W
);
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic            ld_start;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            ld_ready;

  modport master (
    output wrEn, addr_toRAM, data_toRAM, ld_start, ld_valid, ld_data, ld_last,
    input  data_fromRAM, ld_ready
  );

  modport slave (
    input  wrEn, addr_toRAM, data_toRAM, ld_start, ld_valid, ld_data, ld_last,
    output data_fromRAM, ld_ready
  );
endinterface
`default_nettype wire

// File: rtl/vscpu_ram_core.sv
`default_nettype none
// ============================================================================
// Module      : vscpu_ram_core
// Description : Single-port synchronous 2^SIZE x DATA_W RAM, read-first.
// Ports       : clk   clock
//               we    write enable
//               addr  word address
//               wdata write data
//               rdata registered read data (old word on same-address write)
// Revision    : 1.0  initial release
// ============================================================================
module vscpu_ram_core #(
  parameter int SIZE   = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SIZE-1:0]   addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<SIZE)-1];

  // Read samples the array before the write lands: read-first behaviour.
  // No reset: contents survive rst.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vscpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : vscpu_mem_responder
// Description : Memory responder for the VerySimpleCPU. Owns a 2^SIZE x 32
//               RAM, serves CPU reads/writes with one-cycle latency while
//               running, and fills the RAM from a valid/ready word stream
//               while holding the CPU in reset.
// Ports       : clk, rst   clock, synchronous active-high reset
//               mem_bus    slave side of vscpu_mem_responder_if
//               cpu_rst    reset to CPU core, high outside RUN
//               ld_ovf     sticky, load wrapped past the top address
//               wp_err     sticky, CPU wrote into the protected program
// Options     : VSCPU_MEM_WP_EN  write-protect the loaded program image
// Revision    : 1.0  initial release
// ============================================================================
module vscpu_mem_responder
  import vscpu_pkg::*;
#(
  parameter int SIZE = VSCPU_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  vscpu_mem_responder_if.slave   mem_bus,
  output logic                   cpu_rst,
  output logic                   ld_ovf,
  output logic                   wp_err
);

  mem_state_t r_state;
  mem_state_t w_next;

  logic                    r_cpu_rst;
  logic                    r_ld_ready;
  logic                    r_ld_ovf;
  logic                    r_rd_en;
  logic [SIZE-1:0]         r_ld_addr;

  logic                    w_cpu_run;
  logic                    w_ld_fire;
  logic                    w_wrap;
  logic                    w_enter_load;
  logic                    w_wp_block;
  logic                    w_ram_we;
  logic [SIZE-1:0]         w_ram_addr;
  logic [VSCPU_DATA_W-1:0] w_ram_wdata;
  logic [VSCPU_DATA_W-1:0] w_ram_rdata;

  assign w_cpu_run    = (r_state == ST_RUN);
  // ld_ready is high exactly in LOAD, so it doubles as the load qualifier.
  assign w_ld_fire    = mem_bus.ld_valid && r_ld_ready;
  assign w_wrap       = w_ld_fire && (r_ld_addr == '1);
  assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (mem_bus.ld_start) w_next = ST_LOAD;
      ST_LOAD: if (w_ld_fire && mem_bus.ld_last) w_next = ST_HOLD;
      ST_HOLD: w_next = ST_RUN;
      ST_RUN:  if (mem_bus.ld_start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state
  // and carry no combinational path from the loader inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rst  <= 1'b1;
      r_ld_ready <= 1'b0;
      r_rd_en    <= 1'b0;
    end else begin
      r_cpu_rst  <= (w_next != ST_RUN);
      r_ld_ready <= (w_next == ST_LOAD);
      r_rd_en    <= w_cpu_run;
    end
  end

  // --------------------------------------------------------------------------
  // Loader address counter and overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_addr <= '0;
      r_ld_ovf  <= 1'b0;
    end else if (w_enter_load) begin
      r_ld_addr <= '0;
      r_ld_ovf  <= 1'b0;
    end else if (w_ld_fire) begin
      r_ld_addr <= r_ld_addr + SIZE'(1);
      if (w_wrap) begin
        r_ld_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional write protection of the loaded image
  // --------------------------------------------------------------------------
`ifdef VSCPU_MEM_WP_EN
  localparam logic [SIZE:0] C_WP_FULL = {1'b1, {SIZE{1'b0}}};

  logic [SIZE:0] r_wp_limit;
  logic          r_wp_err;

  assign w_wp_block = w_cpu_run && mem_bus.wrEn &&
                      ({1'b0, mem_bus.addr_toRAM} < r_wp_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp_limit <= '0;
      r_wp_err   <= 1'b0;
    end else begin
      // An overflowed image covers the whole RAM, so protect everything.
      if (w_ld_fire && mem_bus.ld_last) begin
        r_wp_limit <= (r_ld_ovf || w_wrap) ? C_WP_FULL
                                           : {1'b0, r_ld_addr} + (SIZE+1)'(1);
      end
      if (w_enter_load) begin
        r_wp_err <= 1'b0;
      end else if (w_wp_block) begin
        r_wp_err <= 1'b1;
      end
    end
  end

  assign wp_err = r_wp_err;
`else
  assign w_wp_block = 1'b0;
  assign wp_err     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // RAM port mux: loader owns it in LOAD, CPU in RUN, idle otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = mem_bus.addr_toRAM;
    w_ram_wdata = mem_bus.data_toRAM;
    if (r_state == ST_LOAD) begin
      w_ram_we    = w_ld_fire;
      w_ram_addr  = r_ld_addr;
      w_ram_wdata = mem_bus.ld_data;
    end else if (w_cpu_run) begin
      w_ram_we    = mem_bus.wrEn && !w_wp_block;
    end
  end

  vscpu_ram_core #(
    .SIZE   (SIZE),
    .DATA_W (VSCPU_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // Read data is only meaningful for reads issued in RUN; otherwise zero.
  assign mem_bus.data_fromRAM = r_rd_en ? w_ram_rdata : '0;
  assign mem_bus.ld_ready     = r_ld_ready;
  assign cpu_rst              = r_cpu_rst;
  assign ld_ovf               = r_ld_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vscpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vscpu_mem_responder
// Description : Self-checking bench for vscpu_mem_responder (SIZE=14 and a
//               SIZE=4 instance for address wrap).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vscpu_mem_responder;
  import vscpu_pkg::*;

`ifdef VSCPU_MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vscpu_mem_responder_if #(.SIZE(14)) b14 ();
  vscpu_mem_responder_if #(.SIZE(4))  b4 ();

  logic cpu_rst14, ld_ovf14, wp_err14;
  logic cpu_rst4, ld_ovf4, wp_err4;

  vscpu_mem_responder #(.SIZE(14)) dut (
    .clk(clk), .rst(rst), .mem_bus(b14),
    .cpu_rst(cpu_rst14), .ld_ovf(ld_ovf14), .wp_err(wp_err14)
  );

  vscpu_mem_responder #(.SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .mem_bus(b4),
    .cpu_rst(cpu_rst4), .ld_ovf(ld_ovf4), .wp_err(wp_err4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m14 [int];     // model of words known to be in the SIZE=14 RAM
  logic [31:0] ld_words [$];  // program to stream into the SIZE=14 instance
  int          prog_len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams ld_words into the SIZE=14 instance, optionally with idle gaps.
  // Returns with the last handshake edge just passed.
  task automatic drive_load14(input bit gaps, output int rdy_cycles, output bit timed_out);
    int idx = 0;
    int guard = 0;
    bit v;
    bit acc;
    rdy_cycles = 0;
    timed_out  = 1'b0;
    b14.ld_start = 1'b1;
    tick();
    b14.ld_start = 1'b0;
    while (idx < ld_words.size()) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      b14.ld_valid = v;
      b14.ld_data  = ld_words[idx];
      b14.ld_last  = (idx == ld_words.size() - 1);
      acc = v && (b14.ld_ready === 1'b1);
      if (b14.ld_ready === 1'b1) rdy_cycles++;
      tick();
      if (acc) begin
        m14[idx] = ld_words[idx];
        idx++;
      end
      guard++;
      if (guard > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    b14.ld_valid = 1'b0;
    b14.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (b14.data_fromRAM !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", b14.data_fromRAM, 32'h0); end
    n_tests++; if (cpu_rst14 !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst14); end
    n_tests++; if (b14.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 0", b14.ld_ready); end
    n_tests++; if (ld_ovf14 !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ovf: got %b expected 0", ld_ovf14); end
    n_tests++; if (wp_err14 !== 1'b0) begin n_fail++; $display("FAIL reset_wp_err: got %b expected 0", wp_err14); end
    n_tests++; if (cpu_rst4 !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst4: got %b expected 1", cpu_rst4); end
    rst = 1'b0;
    // valid without a start pulse must not open the loader
    b14.ld_valid = 1'b1;
    tick();
    tick();
    n_tests++; if (b14.ld_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ld_ready: got %b expected 0", b14.ld_ready); end
    n_tests++; if (cpu_rst14 !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_rst: got %b expected 1", cpu_rst14); end
    b14.ld_valid = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [31:0] exp_w [3] = '{32'h1000_4005, 32'h8000_C002, 32'h0000_0007};
    int rdy;
    bit to;
    ld_words = '{32'h1000_4005, 32'h8000_C002, 32'h0000_0007};
    drive_load14(1'b0, rdy, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL load_basic_timeout: got timeout expected completion"); end
    n_tests++; if (rdy !== 3) begin n_fail++; $display("FAIL load_basic_ready_cycles: got %0d expected 3", rdy); end
    n_tests++; if (cpu_rst14 !== 1'b1) begin n_fail++; $display("FAIL load_basic_hold_cpu_rst: got %b expected 1", cpu_rst14); end
    n_tests++; if (b14.ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_basic_hold_ready: got %b expected 0", b14.ld_ready); end
    tick();
    n_tests++; if (cpu_rst14 !== 1'b0) begin n_fail++; $display("FAIL load_basic_run_cpu_rst: got %b expected 0", cpu_rst14); end
    n_tests++; if (b14.data_fromRAM !== 32'h0) begin n_fail++; $display("FAIL load_basic_pre_run_data: got %h expected 0", b14.data_fromRAM); end
    for (int i = 0; i < 3; i++) begin
      b14.addr_toRAM = 14'(i);
      tick();
      n_tests++; if (b14.data_fromRAM !== exp_w[i]) begin n_fail++; $display("FAIL load_basic_read%0d: got %h expected %h", i, b14.data_fromRAM, exp_w[i]); end
    end
    prog_len = 3;
  endtask

  task automatic test_cpu_write();
    b14.wrEn = 1'b1; b14.addr_toRAM = 14'd100; b14.data_toRAM = 32'hDEAD_BEEF;
    tick();
    b14.wrEn = 1'b0;
    tick();
    n_tests++; if (b14.data_fromRAM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_write_read: got %h expected %h", b14.data_fromRAM, 32'hDEAD_BEEF); end
    b14.wrEn = 1'b1; b14.data_toRAM = 32'h5;
    tick();
    b14.wrEn = 1'b0;
    n_tests++; if (b14.data_fromRAM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_first: got %h expected %h", b14.data_fromRAM, 32'hDEAD_BEEF); end
    tick();
    n_tests++; if (b14.data_fromRAM !== 32'h5) begin n_fail++; $display("FAIL cpu_write_second: got %h expected %h", b14.data_fromRAM, 32'h5); end
    m14[100] = 32'h5;
  endtask

  task automatic test_start_in_run();
    logic [31:0] x1 = $urandom();
    logic [31:0] x2 = ~x1;
    int rdy;
    bit to;
    b14.ld_start = 1'b1; b14.wrEn = 1'b1; b14.addr_toRAM = 14'd200; b14.data_toRAM = x1;
    tick();
    b14.ld_start = 1'b0;
    n_tests++; if (cpu_rst14 !== 1'b1) begin n_fail++; $display("FAIL start_run_cpu_rst: got %b expected 1", cpu_rst14); end
    n_tests++; if (b14.ld_ready !== 1'b1) begin n_fail++; $display("FAIL start_run_ld_ready: got %b expected 1", b14.ld_ready); end
    b14.data_toRAM = x2;
    tick();
    b14.wrEn = 1'b0;
    ld_words = '{$urandom(), $urandom(), $urandom()};
    drive_load14(1'b1, rdy, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL start_run_timeout: got timeout expected completion"); end
    tick();
    n_tests++; if (cpu_rst14 !== 1'b0) begin n_fail++; $display("FAIL start_run_reload_cpu_rst: got %b expected 0", cpu_rst14); end
    b14.addr_toRAM = 14'd200;
    tick();
    n_tests++; if (b14.data_fromRAM !== x1) begin n_fail++; $display("FAIL start_run_write_kept: got %h expected %h", b14.data_fromRAM, x1); end
    m14[200] = x1;
    prog_len = 3;
  endtask

  task automatic test_rst_mid_load();
    logic [31:0] a0 = $urandom();
    logic [31:0] a1 = $urandom();
    logic [31:0] n0 = $urandom();
    int rdy;
    bit to;
    b14.ld_start = 1'b1;
    tick();
    b14.ld_start = 1'b0;
    b14.ld_valid = 1'b1; b14.ld_last = 1'b0; b14.ld_data = a0;
    tick();
    b14.ld_data = a1;
    tick();
    b14.ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m14[0] = a0;
    m14[1] = a1;
    n_tests++; if (cpu_rst14 !== 1'b1) begin n_fail++; $display("FAIL abort_cpu_rst: got %b expected 1", cpu_rst14); end
    n_tests++; if (b14.ld_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ld_ready: got %b expected 0", b14.ld_ready); end
    // CPU write outside RUN must not land
    b14.wrEn = 1'b1; b14.addr_toRAM = 14'd1; b14.data_toRAM = ~a1;
    tick();
    b14.wrEn = 1'b0;
    n_tests++; if (b14.data_fromRAM !== 32'h0) begin n_fail++; $display("FAIL idle_read_zero: got %h expected 0", b14.data_fromRAM); end
    ld_words = '{n0};
    drive_load14(1'b0, rdy, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL abort_reload_timeout: got timeout expected completion"); end
    tick();
    b14.addr_toRAM = 14'd0;
    tick();
    n_tests++; if (b14.data_fromRAM !== n0) begin n_fail++; $display("FAIL abort_restart_addr0: got %h expected %h", b14.data_fromRAM, n0); end
    b14.addr_toRAM = 14'd1;
    tick();
    n_tests++; if (b14.data_fromRAM !== a1) begin n_fail++; $display("FAIL abort_retained_addr1: got %h expected %h", b14.data_fromRAM, a1); end
    prog_len = 1;
  endtask

  task automatic test_random_load();
    int len = $urandom_range(20, 40);
    int rdy;
    bit to;
    ld_words.delete();
    for (int i = 0; i < len; i++) ld_words.push_back($urandom());
    drive_load14(1'b1, rdy, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rand_load_timeout: got timeout expected completion"); end
    n_tests++; if (ld_ovf14 !== 1'b0) begin n_fail++; $display("FAIL rand_load_ovf: got %b expected 0", ld_ovf14); end
    tick();
    for (int i = 0; i < len; i++) begin
      b14.addr_toRAM = 14'(i);
      tick();
      n_tests++; if (b14.data_fromRAM !== m14[i]) begin n_fail++; $display("FAIL rand_load_read%0d: got %h expected %h", i, b14.data_fromRAM, m14[i]); end
    end
    prog_len = len;
  endtask

  task automatic test_random_cpu();
    int a;
    bit we;
    bit have;
    bit wp_exp = 1'b0;
    logic [31:0] d;
    logic [31:0] ev;
    for (int c = 0; c < 300; c++) begin
      a  = $urandom_range(0, prog_len + 7);
      we = ($urandom_range(0, 2) == 0);
      d  = $urandom();
      b14.addr_toRAM = 14'(a); b14.wrEn = we; b14.data_toRAM = d;
      have = (m14.exists(a) != 0);
      ev   = have ? m14[a] : 32'h0;
      if (we) begin
        if (WP_ON && a < prog_len) wp_exp = 1'b1;
        else m14[a] = d;
      end
      tick();
      if (have) begin
        n_tests++; if (b14.data_fromRAM !== ev) begin n_fail++; $display("FAIL rand_cpu_read a=%0d: got %h expected %h", a, b14.data_fromRAM, ev); end
      end
    end
    b14.wrEn = 1'b0;
    n_tests++; if (wp_err14 !== wp_exp) begin n_fail++; $display("FAIL rand_cpu_wp_err: got %b expected %b", wp_err14, wp_exp); end
  endtask

  task automatic test_wp();
    logic [31:0] q = $urandom();
    logic [31:0] r = $urandom();
    int rdy;
    bit to;
    ld_words = '{$urandom(), $urandom(), $urandom()};
    drive_load14(1'b0, rdy, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL wp_load_timeout: got timeout expected completion"); end
    n_tests++; if (wp_err14 !== 1'b0) begin n_fail++; $display("FAIL wp_cleared_on_load: got %b expected 0", wp_err14); end
    tick();
    b14.wrEn = 1'b1; b14.addr_toRAM = 14'd2; b14.data_toRAM = q;
    tick();
    b14.wrEn = 1'b0;
    tick();
    n_tests++; if (b14.data_fromRAM !== (WP_ON ? ld_words[2] : q)) begin n_fail++; $display("FAIL wp_addr2: got %h expected %h", b14.data_fromRAM, (WP_ON ? ld_words[2] : q)); end
    n_tests++; if (wp_err14 !== WP_ON) begin n_fail++; $display("FAIL wp_err_set: got %b expected %b", wp_err14, WP_ON); end
    b14.wrEn = 1'b1; b14.addr_toRAM = 14'd3; b14.data_toRAM = r;
    tick();
    b14.wrEn = 1'b0;
    tick();
    n_tests++; if (b14.data_fromRAM !== r) begin n_fail++; $display("FAIL wp_addr3: got %h expected %h", b14.data_fromRAM, r); end
    n_tests++; if (wp_err14 !== WP_ON) begin n_fail++; $display("FAIL wp_err_sticky: got %b expected %b", wp_err14, WP_ON); end
    b14.ld_start = 1'b1;
    tick();
    b14.ld_start = 1'b0;
    n_tests++; if (wp_err14 !== 1'b0) begin n_fail++; $display("FAIL wp_err_restart: got %b expected 0", wp_err14); end
  endtask

  task automatic test_ovf();
    logic [31:0] w [17];
    logic [31:0] m4 [16];
    int idx = 0;
    int guard = 0;
    for (int k = 0; k < 17; k++) w[k] = $urandom();
    for (int k = 0; k < 17; k++) m4[k % 16] = w[k];
    b4.ld_start = 1'b1;
    tick();
    b4.ld_start = 1'b0;
    while (idx < 17 && guard < 200) begin
      b4.ld_valid = 1'b1; b4.ld_data = w[idx]; b4.ld_last = (idx == 16);
      if (b4.ld_ready === 1'b1) begin
        tick();
        idx++;
      end else begin
        tick();
      end
      guard++;
    end
    b4.ld_valid = 1'b0; b4.ld_last = 1'b0;
    n_tests++; if (idx != 17) begin n_fail++; $display("FAIL ovf_load_timeout: got %0d words expected 17", idx); end
    n_tests++; if (ld_ovf4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ld_ovf4); end
    tick();
    n_tests++; if (cpu_rst4 !== 1'b0) begin n_fail++; $display("FAIL ovf_cpu_rst: got %b expected 0", cpu_rst4); end
    for (int i = 0; i < 16; i++) begin
      b4.addr_toRAM = 4'(i);
      tick();
      n_tests++; if (b4.data_fromRAM !== m4[i]) begin n_fail++; $display("FAIL ovf_read%0d: got %h expected %h", i, b4.data_fromRAM, m4[i]); end
    end
    b4.ld_start = 1'b1;
    tick();
    b4.ld_start = 1'b0;
    n_tests++; if (ld_ovf4 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_on_start: got %b expected 0", ld_ovf4); end
  endtask

  initial begin
    rst = 1'b1;
    b14.wrEn = 1'b0; b14.addr_toRAM = '0; b14.data_toRAM = '0;
    b14.ld_start = 1'b0; b14.ld_valid = 1'b0; b14.ld_data = '0; b14.ld_last = 1'b0;
    b4.wrEn = 1'b0; b4.addr_toRAM = '0; b4.data_toRAM = '0;
    b4.ld_start = 1'b0; b4.ld_valid = 1'b0; b4.ld_data = '0; b4.ld_last = 1'b0;
    prog_len = 0;
    test_reset();
    test_load_basic();
    test_cpu_write();
    test_start_in_run();
    test_rst_mid_load();
    test_random_load();
    test_random_cpu();
    test_wp();
    test_ovf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
